// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tt_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  // Dwell counter width: clog2(dwell), never less than one bit.
  function automatic int unsigned dwell_w(input int unsigned dwell);
    return (dwell <= 1) ? 1 : $clog2(dwell);
  endfunction

endpackage

// File: rtl/tt_dwell_timer.sv
// Parametrised up/down dwell counter with clear and terminal-count strobe.
module tt_dwell_timer
  import tt_pkg::*;
#(
  parameter int unsigned LIMIT = 10,
  parameter bit          DOWN  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = dwell_w(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] INIT = DOWN ? LAST : '0;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= INIT;
    else if (clr) cnt <= INIT;
    else if (en)  cnt <= DOWN ? cnt - 1'b1 : cnt + 1'b1;
  end

  assign tc = DOWN ? (cnt == '0) : (cnt == LAST);

endmodule

// File: rtl/tt_sweeper.sv
// Exhaustive truth-table sweeper: drives all 2^N_IN vectors and checks dut_f
// against GOLDEN. Optional fail log enabled by TT_SWEEPER_FAILLOG_EN.
module tt_sweeper
  import tt_pkg::*;
#(
  parameter int unsigned           N_IN   = 4,
  parameter int unsigned           DWELL  = 10,
  parameter logic [(1<<N_IN)-1:0]  GOLDEN = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_f,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt
`ifdef TT_SWEEPER_FAILLOG_EN
  ,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_vld
`endif
);

  localparam logic [N_IN:0] LAST_VEC = {1'b0, {N_IN{1'b1}}};

  state_t        state, state_nx;
  logic [N_IN:0] vec;
  logic          tc, accept, sample, last, miss;

  assign accept = start && (state != DRIVE);
  assign sample = (state == DRIVE) && tc;
  assign last   = (vec == LAST_VEC);
  assign miss   = sample && (dut_f != GOLDEN[vec[N_IN-1:0]]);

  tt_dwell_timer #(
    .LIMIT (DWELL),
    .DOWN  (1'b0)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept || sample),
    .en    (state == DRIVE),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (accept) state_nx = DRIVE;
      DRIVE:      if (sample && last) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DRIVE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec     <= '0;
      err_cnt <= '0;
    end else if (accept) begin
      vec     <= '0;
      err_cnt <= '0;
    end else begin
      if (sample && !last) vec <= vec + 1'b1;
      if (miss)            err_cnt <= err_cnt + 1'b1;
    end
  end

  assign stim = vec[N_IN-1:0];
  assign pass = done && (err_cnt == '0);

`ifdef TT_SWEEPER_FAILLOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else if (accept) begin
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else if (miss && !first_fail_vld) begin
      first_fail     <= vec[N_IN-1:0];
      first_fail_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tt_sweeper.sv
// Randomized bench for tt_sweeper: a 4-input/DWELL=10 instance and a
// 2-input/DWELL=1 instance, checked against a truth-table reference model.
module tb_tt_sweeper;

  localparam logic [15:0] G1 = 16'h8000;
  localparam logic [3:0]  G2 = 4'b0110;

  logic clk, rst_n, start1, start2;
  logic [15:0] tbl1;
  logic [3:0]  tbl2;
  logic        f1, f2;
  logic [3:0]  stim1;
  logic [1:0]  stim2;
  logic        busy1, done1, pass1, busy2, done2, pass2;
  logic [4:0]  err1;
  logic [2:0]  err2;
`ifdef TT_SWEEPER_FAILLOG_EN
  logic [3:0]  ff1;
  logic [1:0]  ff2;
  logic        ffv1, ffv2;
`endif

  int n_checks = 0;
  int n_err = 0;
  int sel = 1;

  logic [7:0] o_stim;
  logic [8:0] o_err;
  logic       o_busy, o_done, o_pass;
`ifdef TT_SWEEPER_FAILLOG_EN
  logic [7:0] o_ff;
  logic       o_ffv;
`endif

  assign f1 = tbl1[stim1];
  assign f2 = tbl2[stim2];

  tt_sweeper #(.N_IN(4), .DWELL(10), .GOLDEN(G1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_f(f1), .stim(stim1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef TT_SWEEPER_FAILLOG_EN
    , .first_fail(ff1), .first_fail_vld(ffv1)
`endif
  );

  tt_sweeper #(.N_IN(2), .DWELL(1), .GOLDEN(G2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_f(f2), .stim(stim2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
`ifdef TT_SWEEPER_FAILLOG_EN
    , .first_fail(ff2), .first_fail_vld(ffv2)
`endif
  );

  always_comb begin
    if (sel == 2) begin
      o_stim = {6'b0, stim2}; o_err = {6'b0, err2};
      o_busy = busy2; o_done = done2; o_pass = pass2;
`ifdef TT_SWEEPER_FAILLOG_EN
      o_ff = {6'b0, ff2}; o_ffv = ffv2;
`endif
    end else begin
      o_stim = {4'b0, stim1}; o_err = {4'b0, err1};
      o_busy = busy1; o_done = done1; o_pass = pass1;
`ifdef TT_SWEEPER_FAILLOG_EN
      o_ff = {4'b0, ff1}; o_ffv = ffv1;
`endif
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".stim"}, 32'(o_stim), 0);
    check({tag, ".busy"}, 32'(o_busy), 0);
    check({tag, ".done"}, 32'(o_done), 0);
    check({tag, ".pass"}, 32'(o_pass), 0);
    check({tag, ".err"},  32'(o_err),  0);
`ifdef TT_SWEEPER_FAILLOG_EN
    check({tag, ".ff"},  32'(o_ff),  0);
    check({tag, ".ffv"}, 32'(o_ffv), 0);
`endif
  endtask

  // One sweep on instance `inst`; optional ignored start at cycle `repulse`
  // and optional asynchronous reset at cycle `rst_at` (aborts the sweep).
  task automatic run_sweep(input int inst, input int repulse, input int rst_at);
    int nv, dw, total, exp_err, first;
    logic [15:0] diff;
    nv = (inst == 1) ? 16 : 4;
    dw = (inst == 1) ? 10 : 1;
    total = nv * dw;
    diff = (inst == 1) ? (tbl1 ^ G1) : {12'b0, tbl2 ^ G2};
    sel = inst;

    @(negedge clk);
    if (inst == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;

    for (int c = 0; c < total; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      exp_err = 0;
      for (int k = 0; k < c / dw; k++) exp_err += int'(diff[k]);
      check("sweep.stim", 32'(o_stim), 32'(c / dw));
      check("sweep.busy", 32'(o_busy), 1);
      check("sweep.done", 32'(o_done), 0);
      check("sweep.err",  32'(o_err),  32'(exp_err));
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_idle("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (inst == 1) start1 = (c == repulse); else start2 = (c == repulse);
    end

    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    exp_err = 0;
    first = -1;
    for (int k = 0; k < nv; k++) begin
      exp_err += int'(diff[k]);
      if (diff[k] && first < 0) first = k;
    end
    check("end.done", 32'(o_done), 1);
    check("end.busy", 32'(o_busy), 0);
    check("end.err",  32'(o_err),  32'(exp_err));
    check("end.pass", 32'(o_pass), (exp_err == 0) ? 1 : 0);
    check("end.stim", 32'(o_stim), 32'(nv - 1));
`ifdef TT_SWEEPER_FAILLOG_EN
    check("end.ffv", 32'(o_ffv), (first >= 0) ? 1 : 0);
    check("end.ff",  32'(o_ff),  (first >= 0) ? 32'(first) : 0);
`endif
    @(posedge clk); #1;
    check("hold.done", 32'(o_done), 1);
    check("hold.busy", 32'(o_busy), 0);
    check("hold.err",  32'(o_err),  32'(exp_err));
  endtask

  function automatic logic [15:0] pick_tbl1(input int mode);
    case (mode)
      0:       return 16'h8000;
      1:       return 16'h0000;
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int rp;
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
    tbl1 = 16'h8000; tbl2 = 4'b0110;
    repeat (3) @(posedge clk);
    #1;
    sel = 1; check_idle("reset1");
    sel = 2; check_idle("reset2");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases on the 4-input instance.
    tbl1 = 16'h8000; run_sweep(1, -1, -1);
    tbl1 = 16'h0000; run_sweep(1, -1, -1);
    tbl1 = 16'hFFFF; run_sweep(1, 50, -1);
    tbl1 = 16'h8000; run_sweep(1, -1, 55);
    sel = 1; check_idle("post_rst");
    run_sweep(1, -1, -1);

    for (int i = 0; i < 6; i++) begin
      tbl1 = pick_tbl1(int'($urandom_range(0, 3)));
      case ($urandom_range(0, 2))
        0:       rp = -1;
        1:       rp = 159;
        default: rp = int'($urandom_range(1, 158));
      endcase
      run_sweep(1, rp, -1);
    end

    // 2-input XOR instance, including restarts straight from DONE.
    tbl2 = 4'b0110; run_sweep(2, -1, -1);
    tbl2 = 4'b1001; run_sweep(2, 3, -1);
    for (int i = 0; i < 6; i++) begin
      tbl2 = 4'($urandom);
      run_sweep(2, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
